spike_rate_decoder: RTL and testbench

Receive-side companion to the ALIF neuron. It consumes the neuron's one-cycle spike output and turns the spike train into numbers. Two measurements are produced:
- a windowed spike count (rate code), delivered over a valid/ready handshake;
- the inter-spike interval (ISI) in clock cycles.

It sits between the neuron's spike pin and any downstream readout or learning logic.

---
 rtl/spike_rate_decoder.sv | 97 +++++++++
 tb/tb_spike_rate_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: windowed spike count (rate) with a valid/ready handshake,
// plus the inter-spike interval measured in enabled clock cycles.
module spike_rate_decoder #(
  parameter int WINDOW_CYCLES = 64,
  parameter int RATE_WIDTH    = 8,
  parameter int ISI_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  spike,
  output logic [RATE_WIDTH-1:0] rate,
  output logic                  rate_valid,
  input  logic                  rate_ready,
  output logic                  overrun,
  output logic [ISI_WIDTH-1:0]  isi,
  output logic                  isi_valid
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic [WIN_W-1:0]      win_cnt;
  logic [RATE_WIDTH-1:0] spk_cnt;
  logic [RATE_WIDTH-1:0] spk_cnt_next;
  logic                  win_close;
  logic                  xfer;
  logic [ISI_WIDTH-1:0]  isi_cnt;
  logic [ISI_WIDTH-1:0]  isi_cnt_inc;
  logic                  seen;

  always_comb begin
    win_close    = enable && (win_cnt == WIN_LAST);
    xfer         = rate_valid && rate_ready;
    spk_cnt_next = spk_cnt;
    // The closing cycle's spike belongs to the closing window.
    if (enable && spike && (spk_cnt != '1))
      spk_cnt_next = spk_cnt + 1'b1;
    isi_cnt_inc = (isi_cnt == '1) ? isi_cnt : isi_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt <= '0;
      spk_cnt <= '0;
    end else if (enable) begin
      if (win_close) begin
        win_cnt <= '0;
        spk_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        spk_cnt <= spk_cnt_next;
      end
    end
  end

  // A close during a transfer reloads rate and keeps rate_valid high; that is
  // not an overrun, only a close with an unaccepted value is.
  always_ff @(posedge clk) begin
    if (reset) begin
      rate       <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (win_close) begin
      rate       <= spk_cnt_next;
      rate_valid <= 1'b1;
      if (rate_valid && !rate_ready)
        overrun <= 1'b1;
    end else if (xfer) begin
      rate_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      isi_cnt   <= '0;
      isi       <= '0;
      isi_valid <= 1'b0;
      seen      <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (enable) begin
        if (spike) begin
          if (seen) begin
            isi       <= isi_cnt_inc;
            isi_valid <= 1'b1;
          end
          isi_cnt <= '0;
          seen    <= 1'b1;
        end else begin
          isi_cnt <= isi_cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized + directed bench for spike_rate_decoder; two instances (64- and
// 512-cycle windows) share stimulus and are checked against a timestamp model.
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic spike = 1'b0;
  logic rate_ready = 1'b0;

  logic [7:0] rate0, rate1, isi0, isi1;
  logic rate_valid0, rate_valid1, overrun0, overrun1, isi_valid0, isi_valid1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW_CYCLES(64), .RATE_WIDTH(8), .ISI_WIDTH(8)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .spike(spike),
    .rate(rate0), .rate_valid(rate_valid0), .rate_ready(rate_ready),
    .overrun(overrun0), .isi(isi0), .isi_valid(isi_valid0)
  );

  spike_rate_decoder #(.WINDOW_CYCLES(512), .RATE_WIDTH(8), .ISI_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .spike(spike),
    .rate(rate1), .rate_valid(rate_valid1), .rate_ready(rate_ready),
    .overrun(overrun1), .isi(isi1), .isi_valid(isi_valid1)
  );

  // Reference model: window position and spike tally per instance; ISI taken
  // as the difference of enabled-cycle timestamps, clipped to 255.
  int unsigned win[2];
  int unsigned m_pos[2];
  int unsigned m_cnt[2];
  int unsigned m_rate[2];
  bit          m_valid[2];
  bit          m_ovr[2];
  longint unsigned m_t = 0;
  longint unsigned m_last = 0;
  bit          m_seen = 0;
  int unsigned m_isi = 0;
  bit          m_isi_v = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit sp, input bit rdy);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pos[k] = 0; m_cnt[k] = 0; m_rate[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
      end else begin
        bit old_v;
        old_v = m_valid[k];
        if (en && sp && m_cnt[k] < 255) m_cnt[k]++;
        if (en && m_pos[k] == win[k] - 1) begin
          m_rate[k] = m_cnt[k];
          if (old_v && !rdy) m_ovr[k] = 1;
          m_valid[k] = 1;
          m_cnt[k] = 0;
          m_pos[k] = 0;
        end else begin
          if (old_v && rdy) m_valid[k] = 0;
          if (en) m_pos[k]++;
        end
      end
    end
    m_isi_v = 0;
    if (rst) begin
      m_seen = 0;
      m_isi = 0;
    end else if (en) begin
      if (sp) begin
        if (m_seen) begin
          m_isi = (m_t - m_last > 255) ? 255 : int'(m_t - m_last);
          m_isi_v = 1;
        end
        m_last = m_t;
        m_seen = 1;
      end
      m_t++;
    end
  endtask

  task automatic compare_all();
    check("rate64", rate0, m_rate[0]);
    check("rate_valid64", rate_valid0, m_valid[0]);
    check("overrun64", overrun0, m_ovr[0]);
    check("rate512", rate1, m_rate[1]);
    check("rate_valid512", rate_valid1, m_valid[1]);
    check("overrun512", overrun1, m_ovr[1]);
    check("isi", isi0, m_isi);
    check("isi_valid", isi_valid0, m_isi_v);
    check("isi_b", isi1, m_isi);
    check("isi_valid_b", isi_valid1, m_isi_v);
  endtask

  task automatic step(input bit rst, input bit en, input bit sp, input bit rdy);
    @(negedge clk);
    reset = rst; enable = en; spike = sp; rate_ready = rdy;
    @(posedge clk);
    model_step(rst, en, sp, rdy);
    #1;
    compare_all();
  endtask

  task automatic run_seg(input int len, input int sp_pct, input int en_pct, input int rdy_pct);
    for (int i = 0; i < len; i++)
      step(1'b0, $urandom_range(99) < en_pct, $urandom_range(99) < sp_pct,
           $urandom_range(99) < rdy_pct);
  endtask

  initial begin
    win[0] = 64;
    win[1] = 512;
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0; m_cnt[k] = 0; m_rate[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
    end

    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    check("reset_rate", rate0, 0);
    check("reset_isi", isi0, 0);

    // All-spike window with ready high
    for (int i = 0; i < 64; i++) step(0, 1, 1, 1);
    check("p1_rate", rate0, 64);
    check("p1_valid", rate_valid0, 1);
    step(0, 1, 0, 1);
    check("p1_valid_drop", rate_valid0, 0);

    // Spike every 4th cycle
    step(1, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(0, 1, (i % 4) == 0, 1);
    check("p2_rate", rate0, 16);

    // Two unconsumed closes: 5 then 9 spikes
    step(1, 0, 0, 0);
    for (int i = 0; i < 128; i++) step(0, 1, (i < 5) || (i >= 64 && i < 73), 0);
    check("p4_rate", rate0, 9);
    check("p4_overrun", overrun0, 1);
    step(0, 1, 0, 1);
    check("p4_valid_clr", rate_valid0, 0);
    check("p4_overrun_sticky", overrun0, 1);

    // Reset mid-window, then a full idle window
    step(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 1, i < 3, 1);
    step(1, 1, 1, 1);
    for (int i = 0; i < 70; i++) step(0, 1, 0, 1);

    // Pause with ignored spikes
    for (int i = 0; i < 20; i++) step(0, 1, (i % 5) == 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 60; i++) step(0, 1, (i % 7) == 3, 1);

    // ISI saturation, then rate saturation on the long window
    step(0, 1, 1, 1);
    for (int i = 0; i < 300; i++) step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    check("p3_isi_sat", isi0, 255);
    step(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) step(0, 1, 1, 1);

    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(4))
        0: run_seg(int'($urandom_range(200, 50)), 50, 90, 70);
        1: run_seg(int'($urandom_range(300, 100)), 5, 100, 50);
        2: run_seg(int'($urandom_range(200, 50)), 90, 60, 20);
        3: run_seg(int'($urandom_range(150, 30)), 30, 80, 0);
        default: step(1, $urandom_range(1), $urandom_range(1), $urandom_range(1));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
